// File: rtl/soc_riscv_ahb4_slave_mem_if.sv
// rtl/soc_riscv_ahb4_slave_mem_if.sv - AHB-Lite bus bundle between a master and the slave memory
interface soc_riscv_ahb4_slave_mem_if #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN
);
  logic                      HSEL;
  logic [PHYS_ADDR_SIZE-1:0] HADDR;
  logic [XLEN-1:0]           HWDATA;
  logic [XLEN-1:0]           HRDATA;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic [3:0]                HPROT;
  logic [1:0]                HTRANS;
  logic                      HMASTLOCK;
  logic                      HREADY;
  logic                      HREADYOUT;
  logic                      HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/soc_riscv_ahb4_slave_mem.sv
// rtl/soc_riscv_ahb4_slave_mem.sv - AHB-Lite slave backed by a word-organised RAM with wait states
module soc_riscv_ahb4_slave_mem #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int MEM_SIZE_BYTES = 4096,
  parameter int WAIT_STATES    = 0
) (
  input logic                       HCLK,
  input logic                       HRESET,
  soc_riscv_ahb4_slave_mem_if.slave ahb
);

  localparam int NBYTES    = XLEN / 8;
  localparam int BYTE_BITS = $clog2(NBYTES);
  localparam int ADDR_BITS = $clog2(MEM_SIZE_BYTES);
  localparam int DEPTH     = MEM_SIZE_BYTES / NBYTES;
  localparam logic [PHYS_ADDR_SIZE:0] MEM_LIMIT = (PHYS_ADDR_SIZE+1)'(MEM_SIZE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               r_state;
  logic                 r_hreadyout;
  logic                 r_hresp;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_write;
  logic [2:0]           r_size;
  logic [XLEN-1:0]      r_mem [DEPTH];

  logic                       w_open;
  logic                       w_accept;
  logic                       w_err;
  logic [7:0]                 w_size_mask;
  logic [ADDR_BITS-BYTE_BITS-1:0] w_word;
  logic                       w_we;
  logic [NBYTES-1:0]          w_be;
  int                         w_lane_lo;
  int                         w_lane_cnt;
  logic                       w_unused;

  // A new address phase can only be taken while this slave is not stalling its own data phase
  assign w_open   = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept = ahb.HREADY && ahb.HSEL && ahb.HTRANS[1] && w_open;

  assign w_size_mask = (8'd1 << ahb.HSIZE) - 8'd1;
  assign w_err = ({1'b0, ahb.HADDR} >= MEM_LIMIT)
              || (ahb.HSIZE > 3'(BYTE_BITS))
              || (|(ahb.HADDR[BYTE_BITS-1:0] & w_size_mask[BYTE_BITS-1:0]));

  assign w_word     = r_addr[ADDR_BITS-1:BYTE_BITS];
  assign w_we       = (r_state == ST_DATA) && r_write;
  assign w_lane_lo  = int'(r_addr[BYTE_BITS-1:0]);
  assign w_lane_cnt = 1 << r_size;

  assign w_unused = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, w_size_mask};

  // Byte lanes covered by the latched transfer size starting at the latched lane offset
  always_comb begin
    w_be = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_be[i] = (i >= w_lane_lo) && (i < w_lane_lo + w_lane_cnt);
    end
  end

  // Transfer sequencing with registered HREADYOUT/HRESP
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          if (w_accept && w_err) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (w_accept && (WAIT_STATES > 0)) begin
            r_state     <= ST_WAIT;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
            r_cnt       <= 4'(WAIT_STATES);
          end else if (w_accept) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Capture the address-phase controls that the data phase needs
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_addr  <= ahb.HADDR[ADDR_BITS-1:0];
      r_write <= ahb.HWRITE;
      r_size  <= ahb.HSIZE;
    end
  end

  // Commit enabled write lanes at the end of the final data cycle; reset aborts the write
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_be[i]) begin
          r_mem[w_word][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign ahb.HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[w_word] : '0;
  assign ahb.HREADYOUT = r_hreadyout;
  assign ahb.HRESP     = r_hresp;

endmodule

// File: tb/tb_soc_riscv_ahb4_slave_mem.sv
// tb/tb_soc_riscv_ahb4_slave_mem.sv - randomized self-checking bench for the AHB slave memory
module tb_soc_riscv_ahb4_slave_mem;

  localparam int NDUT = 3;
  localparam int MEM  = 4096;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        t_rst        [NDUT];
  logic        t_hsel       [NDUT];
  logic [31:0] t_haddr      [NDUT];
  logic [31:0] t_hwdata     [NDUT];
  logic        t_hwrite     [NDUT];
  logic [2:0]  t_hsize      [NDUT];
  logic [1:0]  t_htrans     [NDUT];
  logic        t_hready_low [NDUT];
  logic [31:0] o_rdata      [NDUT];
  logic        o_ready      [NDUT];
  logic        o_resp       [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    soc_riscv_ahb4_slave_mem_if #(.XLEN(32), .PHYS_ADDR_SIZE(32)) u_bus ();
    assign u_bus.HSEL      = t_hsel[g];
    assign u_bus.HADDR     = t_haddr[g];
    assign u_bus.HWDATA    = t_hwdata[g];
    assign u_bus.HWRITE    = t_hwrite[g];
    assign u_bus.HSIZE     = t_hsize[g];
    assign u_bus.HTRANS    = t_htrans[g];
    assign u_bus.HBURST    = 3'd0;
    assign u_bus.HPROT     = 4'h3;
    assign u_bus.HMASTLOCK = 1'b0;
    assign u_bus.HREADY    = u_bus.HREADYOUT && !t_hready_low[g];
    assign o_rdata[g]      = u_bus.HRDATA;
    assign o_ready[g]      = u_bus.HREADYOUT;
    assign o_resp[g]       = u_bus.HRESP;

    soc_riscv_ahb4_slave_mem #(
      .XLEN(32), .PHYS_ADDR_SIZE(32), .MEM_SIZE_BYTES(MEM),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .HCLK(HCLK), .HRESET(t_rst[g]), .ahb(u_bus)
    );
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rdata;
  logic [7:0]  ref_mem [NDUT][MEM];
  xfer_t       q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic bit ref_err(input xfer_t x);
    if (x.addr >= MEM) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    return (x.addr % (32'd1 << x.size)) != 0;
  endfunction

  function automatic logic [31:0] ref_read(input int d, input logic [31:0] addr);
    int base;
    base = int'(addr) - int'(addr) % 4;
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  task automatic ref_write(input int d, input xfer_t x);
    int a;
    for (int b = 0; b < (1 << x.size); b++) begin
      a = int'(x.addr) + b;
      ref_mem[d][a] = x.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic drive_ap(input int d, input xfer_t x);
    t_hsel[d]   = x.sel;
    t_htrans[d] = x.trans;
    t_hwrite[d] = x.write;
    t_haddr[d]  = x.addr;
    t_hsize[d]  = x.size;
  endtask

  // Plays the queued address phases as a pipelined master; the model decides when each data phase ends
  task automatic run_q(input int d);
    xfer_t       dp;
    xfer_t       ap;
    bit          dp_v = 1'b0;
    bit          dp_err = 1'b0;
    bit          exp_rdy;
    bit          exp_resp;
    logic [31:0] exp_rd;
    int          cyc = 0;
    int          ws = ws_of(d);
    last_rdata = 'x;
    while (q.size() > 0 || dp_v) begin
      ap = (q.size() > 0) ? q[0] : mk(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0);
      drive_ap(d, ap);
      t_hwdata[d] = (dp_v && dp.write) ? dp.wdata : $urandom();
      @(negedge HCLK);
      exp_rd = 32'd0;
      if (!dp_v) begin
        exp_rdy = 1'b1; exp_resp = 1'b0;
      end else if (dp_err) begin
        exp_rdy = (cyc == 1); exp_resp = 1'b1;
      end else begin
        exp_rdy = (cyc == ws); exp_resp = 1'b0;
        if (exp_rdy && !dp.write) exp_rd = ref_read(d, dp.addr);
      end
      check($sformatf("hreadyout d%0d a%h", d, dp.addr), 32'(o_ready[d]), 32'(exp_rdy));
      check($sformatf("hresp d%0d a%h", d, dp.addr), 32'(o_resp[d]), 32'(exp_resp));
      check($sformatf("hrdata d%0d a%h", d, dp.addr), o_rdata[d], exp_rd);
      if (dp_v && !dp_err && exp_rdy && !dp.write) last_rdata = o_rdata[d];
      @(posedge HCLK); #1;
      if (exp_rdy) begin
        if (dp_v && !dp_err && dp.write) ref_write(d, dp);
        dp_v = 1'b0;
        if (q.size() > 0) begin
          ap = q.pop_front();
          if (ap.sel && ap.trans[1]) begin
            dp = ap; dp_v = 1'b1; dp_err = ref_err(ap); cyc = 0;
          end
        end
      end else begin
        cyc++;
      end
    end
    drive_ap(d, mk(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t reached limit %0d", $time, 400000);
    $fatal(1);
  end

  initial begin
    logic [31:0] old;
    logic [31:0] addr;
    logic [2:0]  size;
    for (int d = 0; d < NDUT; d++) begin
      t_rst[d] = 1'b1;
      t_hready_low[d] = 1'b0;
      t_hwdata[d] = 32'd0;
      drive_ap(d, mk(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0));
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_rdy d%0d", d), 32'(o_ready[d]), 32'd1);
      check($sformatf("rst_resp d%0d", d), 32'(o_resp[d]), 32'd0);
      check($sformatf("rst_rdata d%0d", d), o_rdata[d], 32'd0);
    end
    @(posedge HCLK); #1;
    for (int d = 0; d < NDUT; d++) t_rst[d] = 1'b0;

    // Prefill a known window in every instance
    for (int d = 0; d < NDUT; d++) begin
      for (int a = 0; a < 128; a += 4) q.push_back(mk(1'b1, 2'd2, 1'b1, 32'(a), 3'd2, $urandom()));
      q.push_back(mk(1'b1, 2'd2, 1'b1, 32'h100, 3'd2, $urandom()));
      run_q(d);
    end

    // Zero-wait write followed immediately by a read of the same word
    q.push_back(mk(1'b1, 2'd2, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h100, 3'd2, 32'd0));
    run_q(0);
    check("pipe_rd", last_rdata, 32'hDEADBEEF);

    // Byte and half-word lanes
    q.push_back(mk(1'b1, 2'd2, 1'b1, 32'h20, 3'd2, 32'h11223344));
    q.push_back(mk(1'b1, 2'd3, 1'b1, 32'h21, 3'd0, 32'h0000AA00));
    q.push_back(mk(1'b1, 2'd3, 1'b1, 32'h22, 3'd1, 32'hBBCC0000));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'd0));
    run_q(0);
    check("lanes", last_rdata, 32'hBBCCAA44);

    // IDLE, BUSY and deselected writes leave the RAM alone
    q.push_back(mk(1'b1, 2'd0, 1'b1, 32'h100, 3'd2, 32'h55555555));
    q.push_back(mk(1'b1, 2'd1, 1'b1, 32'h100, 3'd2, 32'h66666666));
    q.push_back(mk(1'b0, 2'd2, 1'b1, 32'h100, 3'd2, 32'h77777777));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h100, 3'd2, 32'd0));
    run_q(0);
    check("nontrans", last_rdata, 32'hDEADBEEF);

    // Another slave holding HREADY low: nothing is accepted
    t_hready_low[0] = 1'b1;
    drive_ap(0, mk(1'b1, 2'd2, 1'b1, 32'h100, 3'd2, 32'h0BADF00D));
    t_hwdata[0] = 32'h0BADF00D;
    @(negedge HCLK);
    check("hrdy_lo_rdy", 32'(o_ready[0]), 32'd1);
    @(posedge HCLK); #1;
    t_hready_low[0] = 1'b0;
    drive_ap(0, mk(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0));
    @(negedge HCLK);
    check("hrdy_lo_next_rdy", 32'(o_ready[0]), 32'd1);
    check("hrdy_lo_next_resp", 32'(o_resp[0]), 32'd0);
    check("hrdy_lo_next_rd", o_rdata[0], 32'd0);
    @(posedge HCLK); #1;
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h100, 3'd2, 32'd0));
    run_q(0);
    check("hrdy_lo_mem", last_rdata, 32'hDEADBEEF);

    // Two wait states, back-to-back reads, then error responses and a corruption check
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'd0));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h4, 3'd2, 32'd0));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h1000, 3'd2, 32'd0));
    q.push_back(mk(1'b1, 2'd2, 1'b1, 32'h2, 3'd2, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'd0));
    old = ref_read(1, 32'h0);
    run_q(1);
    check("err_noclobber", last_rdata, old);

    // Reset during the second wait cycle of a write aborts it
    old = ref_read(2, 32'h40);
    drive_ap(2, mk(1'b1, 2'd2, 1'b1, 32'h40, 3'd2, 32'd0));
    @(negedge HCLK);
    check("rst_ap_rdy", 32'(o_ready[2]), 32'd1);
    @(posedge HCLK); #1;
    drive_ap(2, mk(1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0));
    t_hwdata[2] = ~old;
    @(negedge HCLK);
    check("rst_w1_rdy", 32'(o_ready[2]), 32'd0);
    @(posedge HCLK); #1;
    t_rst[2] = 1'b1;
    @(negedge HCLK);
    check("rst_w2_rdy", 32'(o_ready[2]), 32'd0);
    @(posedge HCLK); #1;
    t_rst[2] = 1'b0;
    @(negedge HCLK);
    check("rst_after_rdy", 32'(o_ready[2]), 32'd1);
    check("rst_after_resp", 32'(o_resp[2]), 32'd0);
    check("rst_after_rd", o_rdata[2], 32'd0);
    @(posedge HCLK); #1;
    q.push_back(mk(1'b1, 2'd2, 1'b0, 32'h40, 3'd2, 32'd0));
    run_q(2);
    check("rst_old", last_rdata, old);

    // Randomized traffic against the byte-level model
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 80; n++) begin
        size = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
        else addr = 32'($urandom_range(0, 127));
        if (size <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
        q.push_back(mk(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), addr, size, $urandom()));
      end
      run_q(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
